// File: rtl/hsaf_pkg.sv
// hsaf_pkg: state encoding and width helpers shared by the tap sequencer.
package hsaf_pkg;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_FILT     = 3'd2,
        ST_WAIT_ERR = 3'd3,
        ST_UPD      = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/tap_counter.sv
// tap_counter: modulo-N tap index counter with synchronous clear.
module tap_counter
    import hsaf_pkg::*;
#(
    parameter int N = 16,
    localparam int IDXW = idx_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    output logic [IDXW-1:0] idx,
    output logic            last
);
    logic [IDXW-1:0] r_idx;

    assign idx  = r_idx;
    assign last = (r_idx == IDXW'(N - 1));

    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_idx <= '0;
        else if (clr)
            r_idx <= '0;
        else if (en)
            r_idx <= last ? '0 : r_idx + 1'b1;
endmodule

// File: rtl/tap_seq_ctrl.sv
// tap_seq_ctrl: accepts samples, shifts the delay line, and once primed walks
// the tap index through a filter pass and, after the error arrives, an update pass.
module tap_seq_ctrl
    import hsaf_pkg::*;
#(
    parameter int BITSIZE = 8,
    parameter int N = 16,
    localparam int IDXW = idx_w(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] in_data,
    input  logic               flush,
    input  logic               err_valid,
    output logic               shift_en,
    output logic [BITSIZE-1:0] shift_data,
    output logic               pipe_clr,
    output logic [IDXW-1:0]    tap_idx,
    output logic               tap_valid,
    output logic               upd_valid,
    output logic               tap_last,
    output logic               filt_done,
    output logic               primed,
    output logic               busy
);
    localparam int FW = fill_w(N);
    localparam logic [FW-1:0] FULL = FW'(N);

    state_t             r_state, w_next;
    logic [FW-1:0]      r_fill, w_fill_inc;
    logic [BITSIZE-1:0] r_data;
    logic               r_filt_done, r_pipe_clr, w_last, w_accept;

    tap_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (flush),
        .en   (tap_valid | upd_valid),
        .idx  (tap_idx),
        .last (w_last)
    );

    assign w_fill_inc = (r_fill == FULL) ? FULL : r_fill + 1'b1;
    assign w_accept   = (r_state == ST_IDLE) && in_valid && !flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = in_valid ? ST_SHIFT : ST_IDLE;
            ST_SHIFT:    w_next = (w_fill_inc == FULL) ? ST_FILT : ST_IDLE;
            ST_FILT:     w_next = w_last ? ST_WAIT_ERR : ST_FILT;
            ST_WAIT_ERR: w_next = err_valid ? ST_UPD : ST_WAIT_ERR;
            ST_UPD:      w_next = w_last ? ST_IDLE : ST_UPD;
            default:     w_next = ST_IDLE;
        endcase
        if (flush)
            w_next = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fill      <= '0;
            r_data      <= '0;
            r_filt_done <= 1'b0;
            r_pipe_clr  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_fill      <= flush ? '0 : (r_state == ST_SHIFT) ? w_fill_inc : r_fill;
            if (w_accept)
                r_data <= in_data;
            // filt_done is a one-shot marking entry to WAIT_ERR, not the whole wait
            r_filt_done <= !flush && tap_valid && w_last;
            r_pipe_clr  <= flush;
        end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign shift_en   = (r_state == ST_SHIFT);
    assign tap_valid  = (r_state == ST_FILT);
    assign upd_valid  = (r_state == ST_UPD);
    assign tap_last   = w_last && (tap_valid || upd_valid);
    assign shift_data = r_data;
    assign filt_done  = r_filt_done;
    assign pipe_clr   = r_pipe_clr;
    assign primed     = (r_fill == FULL);
endmodule
